multiplier_seq: RTL and testbench

Parametrised iterative multiplier: computes the full 2·WIDTH-bit product of two WIDTH-bit operands, signed (two's complement) or unsigned as selected per operation, using one (WIDTH+1)-bit adder reused over WIDTH cycles. It replaces the fully unrolled combinational array multiplier wherever area matters more than latency. It sits behind valid/ready handshakes on both sides so it can be dropped between pipeline stages of the datapath.

---
 rtl/multiplier_seq.sv | 109 ++++++++++
 tb/tb_multiplier_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_seq.sv
// Iterative shift-add multiplier (signed or unsigned per op): product on DOUT_o WIDTH cycles after accept.
// Valid/ready both sides; DONE holds the result and blocks new input while OUT_READY_i is low.
module multiplier_seq #(
  parameter int WIDTH = 32
) (
  input  logic               CLK_i,
  input  logic               RST_i,
  input  logic               IN_VALID_i,
  output logic               IN_READY_o,
  input  logic               SIGNED_i,
  input  logic [WIDTH-1:0]   DIN1_i,
  input  logic [WIDTH-1:0]   DIN2_i,
  output logic               OUT_VALID_o,
  input  logic               OUT_READY_i,
  output logic [2*WIDTH-1:0] DOUT_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               signed_q, signed_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;

  logic               last_bit;
  logic               sub;
  logic [WIDTH:0]     pp;
  logic [WIDTH:0]     pp_x;
  logic [WIDTH+1:0]   sum;

  // Single (WIDTH+1)-bit adder; sum[WIDTH+1] is its carry-out.
  always_comb begin
    last_bit = (cnt_q == CW'(WIDTH-1));
    sub      = signed_q && last_bit;
    pp       = lo_q[0] ? {signed_q & mcand_q[WIDTH-1], mcand_q} : '0;
    pp_x     = sub ? ~pp : pp;
    sum      = {1'b0, acc_q} + {1'b0, pp_x} + {{(WIDTH+1){1'b0}}, sub};
  end

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    signed_d    = signed_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    IN_READY_o  = 1'b0;
    OUT_VALID_o = 1'b0;
    case (state_q)
      IDLE: begin
        IN_READY_o = 1'b1;
        if (IN_VALID_i) begin
          mcand_d  = DIN1_i;
          lo_d     = DIN2_i;
          signed_d = SIGNED_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // Signed mode shifts arithmetically; unsigned shifts the carry back in.
        acc_d = {(signed_q ? sum[WIDTH] : sum[WIDTH+1]), sum[WIDTH:1]};
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          dout_d  = {acc_d[WIDTH-1:0], lo_d};
          state_d = DONE;
        end
      end
      DONE: begin
        OUT_VALID_o = 1'b1;
        if (OUT_READY_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      signed_q <= 1'b0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      signed_q <= signed_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

  assign DOUT_o = dout_q;

endmodule

// File: tb/tb_multiplier_seq.sv
// Directed bench for multiplier_seq: WIDTH=32 vector table plus multi-cycle corner sequences,
// and a WIDTH=8 instance driven with corner/random operands against a golden model.
module tb_multiplier_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           in_valid, in_ready, sgn, out_valid, out_ready;
  logic [W-1:0]   din1, din2;
  logic [2*W-1:0] dout;

  logic           in_valid8, in_ready8, sgn8, out_valid8, out_ready8;
  logic [7:0]     din1_8, din2_8;
  logic [15:0]    dout8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc8 = -1;

  always @(posedge clk) cyc <= cyc + 1;

  multiplier_seq #(.WIDTH(W)) dut (
    .CLK_i(clk), .RST_i(rst),
    .IN_VALID_i(in_valid), .IN_READY_o(in_ready), .SIGNED_i(sgn),
    .DIN1_i(din1), .DIN2_i(din2),
    .OUT_VALID_o(out_valid), .OUT_READY_i(out_ready), .DOUT_o(dout)
  );

  multiplier_seq #(.WIDTH(8)) dut8 (
    .CLK_i(clk), .RST_i(rst),
    .IN_VALID_i(in_valid8), .IN_READY_o(in_ready8), .SIGNED_i(sgn8),
    .DIN1_i(din1_8), .DIN2_i(din2_8),
    .OUT_VALID_o(out_valid8), .OUT_READY_i(out_ready8), .DOUT_o(dout8)
  );

  typedef struct {
    logic           s;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Accept one op on the 32-bit instance with OUT_READY_i high; scramble inputs after accept.
  task automatic run32(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] res, output int lat);
    int guard;
    guard = 0;
    lat   = -1;
    res   = '0;
    out_ready = 1'b1;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    din1 = a; din2 = b; sgn = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    din1 = ~a; din2 = ~b; sgn = ~s;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        res = dout;
        break;
      end
    end
  endtask

  function automatic logic [15:0] gold8(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    if (s) begin
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      return 16'(sa * sb);
    end
    return {8'b0, a} * {8'b0, b};
  endfunction

  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b);
    int guard;
    int lat;
    int stall;
    logic [15:0] exp;
    exp   = gold8(s, a, b);
    guard = 0;
    lat   = -1;
    out_ready8 = 1'b0;
    while (!in_ready8 && guard < 100) begin
      tick();
      guard++;
    end
    din1_8 = a; din2_8 = b; sgn8 = s; in_valid8 = 1'b1;
    tick();
    if (last_acc8 >= 0) check("w8_ii_ge_10", 64'(cyc - last_acc8 >= 10), 64'd1);
    last_acc8 = cyc;
    in_valid8 = 1'b0;
    din1_8 = 8'($urandom); din2_8 = 8'($urandom); sgn8 = ~s;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (out_valid8) begin
        lat = k;
        break;
      end
    end
    check($sformatf("w8_lat s=%0d a=%h b=%h", s, a, b), 64'(lat), 64'd8);
    check($sformatf("w8_prod s=%0d a=%h b=%h", s, a, b), {48'b0, dout8}, {48'b0, exp});
    stall = $urandom_range(0, 3);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("w8_stall_hold", {47'b0, out_valid8, dout8}, {47'b0, 1'b1, exp});
    end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check("w8_release", {62'b0, out_valid8, in_ready8}, 64'b01);
  endtask

  initial begin
    logic [2*W-1:0] res;
    int             lat;
    int             guard;
    logic           seen;
    logic [7:0]     corners[8];

    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[1] = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[2] = '{1'b1, 32'hFFFFFFFF, 32'h00000007, 64'hFFFFFFFFFFFFFFF9};
    vecs[3] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000};
    vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'h00000007, 64'h00000006FFFFFFF9};
    vecs[5] = '{1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[6] = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001};
    vecs[7] = '{1'b1, 32'hFFFFFFFB, 32'h00000003, 64'hFFFFFFFFFFFFFFF1};
    vecs[8] = '{1'b0, 32'h00000000, 32'hDEADBEEF, 64'h0000000000000000};

    // Reset with IN_VALID_i asserted: must not accept.
    rst = 1'b1;
    in_valid = 1'b1; sgn = 1'b0; din1 = 32'd3; din2 = 32'd4; out_ready = 1'b0;
    in_valid8 = 1'b1; sgn8 = 1'b0; din1_8 = 8'd3; din2_8 = 8'd4; out_ready8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_in_ready", {63'b0, in_ready}, 64'd1);
      check("reset_out_valid", {63'b0, out_valid}, 64'd0);
      check("reset_dout", dout, 64'd0);
    end
    in_valid = 1'b0; in_valid8 = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_after_reset", {62'b0, in_ready, out_valid}, 64'b10);

    for (int i = 0; i < 9; i++) begin
      run32(vecs[i].s, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
      check($sformatf("vec%0d_product", i), res, vecs[i].p);
      check($sformatf("vec%0d_busy_ready", i), {63'b0, in_ready}, 64'd0);
      tick();
      check($sformatf("vec%0d_valid_pulse", i), {62'b0, out_valid, in_ready}, 64'b01);
    end

    // Back-pressure: DONE held for 10 cycles while inputs toggle.
    out_ready = 1'b0;
    din1 = 32'd6; din2 = 32'd7; sgn = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin
      tick();
      guard++;
    end
    check("bp_valid_seen", {63'b0, out_valid}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      din1 = $urandom; din2 = $urandom; sgn = i[0]; in_valid = ~in_valid;
      tick();
      check("bp_hold_dout", dout, 64'd42);
      check("bp_hold_flags", {62'b0, out_valid, in_ready}, 64'b10);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_flags", {62'b0, out_valid, in_ready}, 64'b01);
    check("bp_dout_held_in_idle", dout, 64'd42);

    // Abort with reset at iteration 5.
    din1 = '1; din2 = '1; sgn = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_flags", {62'b0, out_valid, in_ready}, 64'b01);
    check("abort_dout", dout, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", {63'b0, seen}, 64'd0);
    run32(1'b0, 32'd3, 32'd5, res, lat);
    check("after_abort_latency", 64'(lat), 64'd32);
    check("after_abort_product", res, 64'd15);
    tick();

    // WIDTH=8: corner cross-product in both modes, then random pairs.
    corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h02; corners[3] = 8'h7E;
    corners[4] = 8'h7F; corners[5] = 8'h80; corners[6] = 8'h81; corners[7] = 8'hFF;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          run8(m[0], corners[i], corners[j]);
        end
      end
    end
    for (int n = 0; n < 400; n++) begin
      run8(1'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
